// File: rtl/wb_xbar_pkg.sv
// Shared Wishbone widths, bridge state encoding and fault defaults for the
// registered master-to-slaves bridges.
package wb_xbar_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    localparam logic [WB_DW-1:0] WB_ERR_DATA_DEF = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD   = 2'd1,
        ST_FAULT = 2'd2,
        ST_RESP  = 2'd3
    } wb_state_e;

    // Watchdog counter width: enough to hold TIMEOUT, never narrower than 1.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational base/mask address decoder; the lowest matching slave index
// wins, so the hit vector is always one-hot or zero.
module wb_addr_decoder
    import wb_xbar_pkg::*;
#(
    parameter int                   N_SLV    = 4,
    parameter logic [N_SLV*32-1:0]  SLV_ADDR = {N_SLV{32'h0}},
    parameter logic [N_SLV*32-1:0]  SLV_MASK = {N_SLV{32'hFFFFFFFF}}
) (
    input  logic [WB_AW-1:0] adr,
    output logic [N_SLV-1:0] hit,
    output logic             miss
);

    logic found;

    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if (!found &&
                ((adr & SLV_MASK[32*i +: 32]) ==
                 (SLV_ADDR[32*i +: 32] & SLV_MASK[32*i +: 32]))) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
        miss = !found;
    end

endmodule

// File: rtl/wishbone_1mst_to_nslv_reg.sv
// Registered Wishbone classic bridge, one master to N_SLV slaves, with a
// latched decode, a bus-timeout watchdog and error answers for faults.
module wishbone_1mst_to_nslv_reg
    import wb_xbar_pkg::*;
#(
    parameter int                   N_SLV    = 4,
    parameter logic [N_SLV*32-1:0]  SLV_ADDR = {N_SLV{32'h0}},
    parameter logic [N_SLV*32-1:0]  SLV_MASK = {N_SLV{32'hFFFFFFFF}},
    parameter int                   TIMEOUT  = 255,
    parameter bit                   ERR_EN   = 1'b1,
    parameter logic [WB_DW-1:0]     ERR_DATA = WB_ERR_DATA_DEF
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  m_cyc_i,
    input  logic                  m_stb_i,
    input  logic [WB_AW-1:0]      m_adr_i,
    input  logic                  m_we_i,
    input  logic [WB_DW-1:0]      m_dat_i,
    input  logic [WB_SW-1:0]      m_sel_i,
    output logic [WB_DW-1:0]      m_dat_o,
    output logic                  m_ack_o,
    output logic                  m_err_o,
    output logic [N_SLV-1:0]      s_cyc_o,
    output logic [N_SLV-1:0]      s_stb_o,
    output logic [WB_AW-1:0]      s_adr_o,
    output logic                  s_we_o,
    output logic [WB_DW-1:0]      s_dat_o,
    output logic [WB_SW-1:0]      s_sel_o,
    input  logic [N_SLV*32-1:0]   s_dat_i,
    input  logic [N_SLV-1:0]      s_ack_i,
    output logic [WB_AW-1:0]      fault_adr_o,
    output logic [7:0]            fault_cnt_o
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // Handshake: a request is m_cyc_i & m_stb_i held by the master until it
    // sees a one-cycle m_ack_o or m_err_o; a slave completes its part by
    // raising s_ack_i while its s_stb_o is high. Dropping m_cyc_i aborts.
    wb_state_e          state, state_nxt;
    logic [N_SLV-1:0]   sel_q, sel_d;
    logic [CW-1:0]      cnt, cnt_d;
    logic [WB_DW-1:0]   dat_d;
    logic               ack_d, err_d;
    logic [WB_AW-1:0]   fault_adr_d;
    logic [7:0]         fault_cnt_d;

    logic [N_SLV-1:0]   hit;
    logic               miss;
    logic               m_req;
    logic               sel_ack;
    logic [WB_DW-1:0]   sel_dat;

    wb_addr_decoder #(
        .N_SLV    (N_SLV),
        .SLV_ADDR (SLV_ADDR),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .adr  (m_adr_i),
        .hit  (hit),
        .miss (miss)
    );

    assign m_req   = m_cyc_i & m_stb_i;
    assign sel_ack = |(sel_q & s_ack_i);

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel_q[i]) sel_dat = sel_dat | s_dat_i[32*i +: 32];
        end
    end

    // Slave strobes follow the master live so an abort drops them at once.
    assign s_cyc_o = (state == ST_FWD) ? (sel_q & {N_SLV{m_req}}) : '0;
    assign s_stb_o = (state == ST_FWD) ? (sel_q & {N_SLV{m_req}}) : '0;
    assign s_adr_o = m_adr_i;
    assign s_we_o  = m_we_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            sel_q       <= '0;
            cnt         <= '0;
            m_dat_o     <= '0;
            m_ack_o     <= 1'b0;
            m_err_o     <= 1'b0;
            fault_adr_o <= '0;
            fault_cnt_o <= '0;
        end else begin
            state       <= state_nxt;
            sel_q       <= sel_d;
            cnt         <= cnt_d;
            m_dat_o     <= dat_d;
            m_ack_o     <= ack_d;
            m_err_o     <= err_d;
            fault_adr_o <= fault_adr_d;
            fault_cnt_o <= fault_cnt_d;
        end
    end

    always_comb begin
        state_nxt   = state;
        sel_d       = sel_q;
        cnt_d       = cnt;
        dat_d       = m_dat_o;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        fault_adr_d = fault_adr_o;
        fault_cnt_d = fault_cnt_o;
        case (state)
            ST_IDLE: begin
                if (m_req) begin
                    sel_d     = hit;
                    cnt_d     = '0;
                    state_nxt = miss ? ST_FAULT : ST_FWD;
                end
            end
            ST_FWD: begin
                cnt_d = cnt + 1'b1;
                if (!m_cyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (sel_ack) begin
                    dat_d     = sel_dat;
                    ack_d     = 1'b1;
                    state_nxt = ST_RESP;
                end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_FAULT: begin
                dat_d       = ERR_DATA;
                err_d       = ERR_EN;
                ack_d       = !ERR_EN;
                fault_adr_d = m_adr_i;
                if (fault_cnt_o != 8'hFF) fault_cnt_d = fault_cnt_o + 8'd1;
                state_nxt   = ST_RESP;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wishbone_1mst_to_nslv_reg.sv
// Self-checking bench: two bridges (faults on err / faults on ack) share one
// master and a set of wait-state slave models; a reference model predicts each answer.
module tb_wishbone_1mst_to_nslv_reg;

  localparam logic [127:0] ADDR_MAP = {32'h3000_0000, 32'h3000_2000, 32'h3000_1000, 32'h3000_0000};
  localparam logic [127:0] MASK_MAP = {32'hFFFF_C000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};
  localparam int TMO = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
  logic [31:0] m_adr = '0, m_dat = '0;
  logic [3:0]  m_sel = '0;

  logic [31:0] a_dat, a_adr, a_sdat, a_fadr, b_dat, b_adr, b_sdat, b_fadr;
  logic        a_ack, a_err, a_we, b_ack, b_err, b_we;
  logic [3:0]  a_cyc, a_stb, a_sel, b_cyc, b_stb, b_sel;
  logic [7:0]  a_fcnt, b_fcnt;
  logic [127:0] s_dat;
  logic [3:0]  s_ack, slv_ack;
  logic [3:0]  noise = '0;
  bit          noise_on = 1'b0;

  int          slv_wait[4];
  logic [31:0] slv_rdata[4];
  int          wcnt[4];

  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_fcnt = 0;
  logic [31:0] exp_fadr = '0;
  logic [31:0] last_dat = '0;

  wishbone_1mst_to_nslv_reg #(
    .N_SLV(4), .SLV_ADDR(ADDR_MAP), .SLV_MASK(MASK_MAP),
    .TIMEOUT(TMO), .ERR_EN(1'b1), .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_adr_i(m_adr), .m_we_i(m_we),
    .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_dat_o(a_dat), .m_ack_o(a_ack), .m_err_o(a_err),
    .s_cyc_o(a_cyc), .s_stb_o(a_stb), .s_adr_o(a_adr), .s_we_o(a_we),
    .s_dat_o(a_sdat), .s_sel_o(a_sel),
    .s_dat_i(s_dat), .s_ack_i(s_ack),
    .fault_adr_o(a_fadr), .fault_cnt_o(a_fcnt)
  );

  wishbone_1mst_to_nslv_reg #(
    .N_SLV(4), .SLV_ADDR(ADDR_MAP), .SLV_MASK(MASK_MAP),
    .TIMEOUT(TMO), .ERR_EN(1'b0), .ERR_DATA(32'hDEADBEEF)
  ) dut_ne (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_adr_i(m_adr), .m_we_i(m_we),
    .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_dat_o(b_dat), .m_ack_o(b_ack), .m_err_o(b_err),
    .s_cyc_o(b_cyc), .s_stb_o(b_stb), .s_adr_o(b_adr), .s_we_o(b_we),
    .s_dat_o(b_sdat), .s_sel_o(b_sel),
    .s_dat_i(s_dat), .s_ack_i(s_ack),
    .fault_adr_o(b_fadr), .fault_cnt_o(b_fcnt)
  );

  // slave models: slave i acks after slv_wait[i] strobed cycles
  always_comb begin
    slv_ack = '0;
    s_dat   = '0;
    for (int i = 0; i < 4; i++) begin
      slv_ack[i] = a_stb[i] && (wcnt[i] == slv_wait[i]);
      s_dat[32*i +: 32] = slv_rdata[i];
    end
  end
  assign s_ack = slv_ack | (noise & ~a_stb);

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      wcnt[i] <= (a_stb[i] && !slv_ack[i]) ? wcnt[i] + 1 : 0;
    end
  end

  always @(negedge clk) noise <= noise_on ? 4'($urandom) : 4'b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // reference address map by region
  function automatic int exp_slave(input logic [31:0] adr);
    if (adr[31:12] == 20'h30000) return 0;
    if (adr[31:12] == 20'h30001) return 1;
    if (adr[31:12] == 20'h30002) return 2;
    if (adr[31:14] == 18'h0C000) return 3;
    return -1;
  endfunction

  // one transfer; called and returns at #1 after a rising edge
  task automatic xfer(input logic [31:0] adr, input int wt, input logic [31:0] rd);
    int ts, n_stb, resp_k, got_k, stb_cnt, bad;
    logic fault;
    logic [3:0] oh;
    logic [31:0] exp_d;
    ts = exp_slave(adr);
    for (int i = 0; i < 4; i++) begin
      slv_rdata[i] = $urandom;
      slv_wait[i]  = $urandom_range(0, 3);
    end
    oh = '0;
    if (ts >= 0) begin
      slv_rdata[ts] = rd;
      slv_wait[ts]  = wt;
      oh = 4'(1 << ts);
    end
    fault  = (ts < 0) || (wt >= TMO);
    n_stb  = (ts < 0) ? 0 : (wt < TMO) ? wt + 1 : TMO;
    resp_k = (ts < 0) ? 2 : (wt < TMO) ? wt + 2 : TMO + 2;
    exp_q.push_back(fault ? 32'hDEADBEEF : rd);
    if (fault) begin
      if (exp_fcnt < 255) exp_fcnt++;
      exp_fadr = adr;
    end
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = adr;
    m_we = 1'($urandom); m_dat = $urandom; m_sel = 4'($urandom);
    #1;
    chk("s_adr", a_adr, adr);
    chk("s_dat", a_sdat, m_dat);
    chk("s_we_sel", {27'b0, a_we, a_sel}, {27'b0, m_we, m_sel});
    got_k = -1; stb_cnt = 0; bad = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (oh != 0 && a_stb == oh) stb_cnt++;
      else if (a_stb != 0) bad++;
      if (b_stb != a_stb || a_cyc != a_stb || b_cyc != b_stb) bad++;
      if (a_ack | a_err | b_ack | b_err) begin
        got_k = k;
        break;
      end
    end
    exp_d = exp_q.pop_front();
    chk("resp_cycle", got_k, resp_k);
    chk("stb_cycles", stb_cnt, n_stb);
    chk("stray_stb", bad, 0);
    chk("err_en1_flags", {30'b0, a_ack, a_err}, {30'b0, !fault, fault});
    chk("err_en0_flags", {30'b0, b_ack, b_err}, {30'b0, 1'b1, 1'b0});
    chk("err_en1_dat", a_dat, exp_d);
    chk("err_en0_dat", b_dat, exp_d);
    chk("fault_cnt", {24'b0, a_fcnt}, exp_fcnt);
    chk("fault_cnt_ne", {24'b0, b_fcnt}, exp_fcnt);
    chk("fault_adr", a_fadr, exp_fadr);
    chk("fault_adr_ne", b_fadr, exp_fadr);
    m_cyc = 1'b0; m_stb = 1'b0;
    last_dat = exp_d;
    @(posedge clk); #1;
    chk("pulse_len", {28'b0, a_ack, a_err, b_ack, b_err}, 0);
    chk("dat_hold", a_dat, last_dat);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_resp"}, {28'b0, a_ack, a_err, b_ack, b_err}, 0);
    chk({tag, "_dat"}, a_dat | b_dat, 0);
    chk({tag, "_stb"}, {24'b0, a_stb, a_cyc}, 0);
    chk({tag, "_stb_ne"}, {24'b0, b_stb, b_cyc}, 0);
    chk({tag, "_fault"}, a_fadr | b_fadr | {24'b0, a_fcnt | b_fcnt}, 0);
  endtask

  initial begin
    int abort_bad;
    logic [31:0] adr;
    int wt;
    for (int i = 0; i < 4; i++) begin
      slv_wait[i] = 0;
      slv_rdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // directed cases
    xfer(32'h3000_1000, 0, 32'h1234_5678);
    xfer(32'h3000_9000, 0, 32'h0);
    xfer(32'h3000_2000, 1000, 32'h0);
    xfer(32'h3000_0ABC, 0, 32'hA5A5_0000);
    xfer(32'h3000_3010, 2, 32'h0303_0303);
    xfer(32'h3000_2004, TMO - 1, 32'h7777_0007);
    xfer(32'h3000_2008, TMO, 32'h8888_0008);

    // abort in the third forwarding cycle
    slv_wait[2] = 1000;
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h3000_2040; m_we = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
    end
    chk("abort_pre_stb", {28'b0, a_stb}, 32'h4);
    m_cyc = 1'b0;
    #1;
    chk("abort_stb", {24'b0, a_stb, b_stb}, 0);
    abort_bad = 0;
    m_stb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (a_ack | a_err | b_ack | b_err) abort_bad++;
    end
    chk("abort_no_resp", abort_bad, 0);
    chk("abort_dat_hold", a_dat, last_dat);
    chk("abort_fault_cnt", {24'b0, a_fcnt}, exp_fcnt);
    xfer(32'h3000_1100, 1, 32'hCAFE_F00D);

    // randomized traffic with stray acks from idle slaves
    for (int n = 0; n < 80; n++) begin
      noise_on = 1'($urandom);
      case ($urandom_range(0, 5))
        0: adr = 32'h3000_0000;
        1: adr = 32'h3000_1000;
        2: adr = 32'h3000_2000;
        3: adr = 32'h3000_3000;
        4: adr = 32'h3000_9000;
        default: adr = $urandom;
      endcase
      if (adr[31:16] == 16'h3000) adr[11:0] = 12'($urandom);
      case ($urandom_range(0, 7))
        0: wt = TMO - 1;
        1: wt = TMO;
        2: wt = 1000;
        default: wt = $urandom_range(0, 3);
      endcase
      xfer(adr, wt, $urandom);
    end
    noise_on = 1'b0;

    // asynchronous reset while forwarding
    slv_wait[2] = 1000;
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h3000_2000;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_stb", {28'b0, a_stb}, 32'h4);
    #2 rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    m_cyc = 1'b0; m_stb = 1'b0;
    exp_fcnt = 0; exp_fadr = '0; last_dat = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // fault counter saturation
    for (int n = 0; n < 300; n++) begin
      adr = 32'h4000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF));
      xfer(adr, 0, 32'h0);
    end
    chk("fault_cnt_sat", {24'b0, a_fcnt}, 32'd255);
    xfer(32'h3000_1FFC, 0, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
